// File: rtl/gate_checker.sv
// Exhaustive 2-input gate checker: drives {A,B} = 00,01,10,11, samples Y, counts mismatches.
// Optional GATE_CHECKER_FAIL_CAPTURE_EN adds fail_valid/fail_vec capture of the first failing vector.
module gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    ,
    output logic       fail_valid,
    output logic [1:0] fail_vec
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    // With no settle time the vector's single cycle is its sample cycle, so DRIVE is skipped.
    localparam state_t     FIRST       = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       mismatch;

    // Case inequality so an X/Z response is scored as a mismatch.
    always_comb mismatch = (Y !== EXPECT[{A, B}]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            A          <= 1'b0;
            B          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FIRST;
                        settle_cnt <= '0;
                        {A, B}     <= 2'b00;
                        err_count  <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 3'd4) err_count <= err_count + 3'd1;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= {A, B};
                        end
`endif
                    end
                    if ({A, B} == 2'b11) begin
                        state <= FINISH;
                    end else begin
                        {A, B} <= {A, B} + 2'd1;
                        state  <= FIRST;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == 3'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: NOR/faulty gate models, mid-run reset, held start, zero settle.
module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       A0, B0, Y0, busy0, done0, pass0;
    logic       A1, B1, Y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    logic       fv0, fv1;
    logic [1:0] fvec0, fvec1;
`endif
    int mode = 0;   // 0 NOR (good), 1 tied 0, 2 AND, 3 OR
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       Y0 = ~(A0 | B0);
            1:       Y0 = 1'b0;
            2:       Y0 = A0 & B0;
            default: Y0 = A0 | B0;
        endcase
    end
    assign Y1 = ~(A1 | B1);

    gate_checker #(.SETTLE_CYCLES(2), .EXPECT(4'b0001)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(A0), .B(B0), .Y(Y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        , .fail_valid(fv0), .fail_vec(fvec0)
`endif
    );

    gate_checker #(.SETTLE_CYCLES(0), .EXPECT(4'b0001)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Y(Y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        , .fail_valid(fv1), .fail_vec(fvec1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full run on dut0; start is also raised in the FINISH cycle, where it must be ignored.
    task automatic run0(input string name, input int exp_err, input int exp_pass, input int exp_fvec);
        start0 = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            if (k == 0) begin
                start0 = 1'b0;
                check({name, ".pass_clr"}, pass0, 0);
                check({name, ".err_clr"}, err0, 0);
            end
            check({name, ".vec"}, {A0, B0}, (k < 12) ? k / 3 : 3);
            check({name, ".busy"}, busy0, 1);
            check({name, ".done_early"}, done0, 0);
            if (k == 12) start0 = 1'b1;
        end
        step();
        start0 = 1'b0;
        check({name, ".done"}, done0, 1);
        check({name, ".busy_end"}, busy0, 0);
        check({name, ".pass"}, pass0, exp_pass);
        check({name, ".err"}, err0, exp_err);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        check({name, ".fail_valid"}, fv0, (exp_err != 0) ? 1 : 0);
        check({name, ".fail_vec"}, fvec0, exp_fvec);
`else
        if (exp_fvec < 0) check({name, ".unused"}, 0, 1);
`endif
        step();
        check({name, ".done_pulse"}, done0, 0);
        check({name, ".no_restart"}, busy0, 0);
        check({name, ".vec_hold"}, {A0, B0}, 3);
        check({name, ".err_hold"}, err0, exp_err);
    endtask

    initial begin
        #2;
        check("rst.async_A", A0, 0);
        check("rst.async_busy", busy0, 0);
        step();
        step();
        rst = 1'b0;
        check("rst.err", err0, 0);
        check("rst.pass", pass0, 0);
        check("rst.done", done0, 0);

        mode = 0; run0("nor", 0, 1, 0);
        mode = 1; run0("tie0", 1, 0, 0);
        mode = 2; run0("and", 2, 0, 0);
        mode = 3; run0("or_sat", 4, 0, 0);

        // Reset during vector 10
        mode = 0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (6) step();
        check("mid.vec10", {A0, B0}, 2);
        #2 rst = 1'b1;
        #1;
        check("mid.A", A0, 0);
        check("mid.B", B0, 0);
        check("mid.busy", busy0, 0);
        check("mid.err", err0, 0);
        check("mid.pass", pass0, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check("mid.no_done", done0, 0);
        end
        run0("post_rst", 0, 1, 0);

        // Start held high across two runs
        mode = 0;
        start0 = 1'b1;
        step();
        repeat (12) step();
        check("held.busy_run", busy0, 1);
        step();
        check("held.done", done0, 1);
        check("held.busy_low", busy0, 0);
        step();
        check("held.restart", busy0, 1);
        check("held.done_off", done0, 0);
        check("held.vec", {A0, B0}, 0);
        check("held.pass_clr", pass0, 0);
        start0 = 1'b0;
        repeat (12) step();
        check("held.done2_early", done0, 0);
        step();
        check("held.done2", done0, 1);
        check("held.pass2", pass0, 1);

        // Zero settle cycles on dut1
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("s0.vec0", {A1, B1}, 0);
        check("s0.busy", busy1, 1);
        for (int k = 1; k < 4; k++) begin
            step();
            check("s0.vec", {A1, B1}, k);
        end
        step();
        check("s0.done_early", done1, 0);
        check("s0.hold11", {A1, B1}, 3);
        step();
        check("s0.done", done1, 1);
        check("s0.pass", pass1, 1);
        check("s0.err", err1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
